inst_queue: RTL and testbench
=============================

# inst_queue

Instruction queue between the fetch stage and decode. It buffers returned instruction words together with their PC and fetch exception flags, so fetch can run ahead while decode is stalled. It discards all contents on pipeline flush. Its `full` output feeds the fetch-side stall request.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all entries; highest priority.
- `push_valid`  in  1  fetch presents an instruction this cycle.
- `push_pc`  in  32 (`word_t`)  PC of the pushed instruction.
- `push_inst`  in  32 (`word_t`)  instruction word from the instruction bus.
- `push_except`  in  `exceptType_t`  fetch exception flags (`iaddr_miss`, `iaddr_invalid`, `iaddr_illegal`).
- `push_ready`  out  1  queue accepts a push this cycle.
- `pop_valid`  out  1  head entry available to decode.
- `pop_pc`  out  32  head PC.
- `pop_inst`  out  32  head instruction.
- `pop_except`  out  `exceptType_t`  head exception flags.
- `pop_ready`  in  1  decode consumes the head (not stalled).
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `full`  out  1  `count == DEPTH`.

## Operation
- Storage is a circular buffer.
  - `wr_ptr` and `rd_ptr` are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - Empty: pointers are equal.
  - Full: low bits are equal and the MSBs differ.
- Push handshake:
  - Push is accepted when `push_valid && push_ready`.
  - `push_ready = !full && !exc_hold && !flush`.
  - `push_ready` is based on registered state: a push while full is rejected, even if a pop happens in the same cycle.
- Pop handshake: pop occurs when `pop_valid && pop_ready`; `rd_ptr` advances by 1.
- Exception sanitising: if any bit of `push_except` is set on an accepted push, the stored instruction is 32'h0 (NOP). PC and except are stored unchanged.
- Exception hold (state bit `exc_hold`):
  - Accepting an entry with a nonzero except sets `exc_hold`.
  - While `exc_hold` is set, `push_ready` stays 0. Instructions past a faulting PC are useless.
  - Only `flush` or `rst` clears `exc_hold`.
- Flush:
  - Next cycle, both pointers are 0, `count` is 0 and `exc_hold` is 0.
  - A push or pop presented in the same cycle as flush has no effect.
- When `pop_valid` is 0, `pop_pc`, `pop_inst` and `pop_except` are driven to 0.
- Simultaneous push and pop when neither empty nor full: both proceed and `count` is unchanged.

## Timing
- Reset values:
  - `push_ready` = 1; `pop_valid` = 0; `count` = 0; `full` = 0.
  - `pop_pc`, `pop_inst`, `pop_except` = 0.
  - `exc_hold` = 0; pointers = 0.
- Latency:
  - A push accepted in cycle N is visible at the head in cycle N+1 (without bypass).
  - `count` and `full` update in the cycle after the push/pop edge.
- Pointer wrap: after DEPTH pushes, `wr_ptr` low bits return to 0 and its MSB toggles.
- Reset mid-operation has the same effect as flush and additionally forces all outputs to their reset values on the next edge.
- `flush` and `rst` asserted together behave as `rst`.

## Configuration
- Macro: `INST_QUEUE_BYPASS_EN`.
- Defined:
  - When the queue is empty, `push_valid && push_ready && pop_ready` passes the push combinationally to the pop outputs in the same cycle.
  - `pop_valid` = 1 in that cycle, and the entry is not written into storage.
  - The sanitising and `exc_hold` rules still apply.
  - Flush still blocks the bypass.
- Not defined: minimum push-to-pop latency is 1 cycle; `pop_valid` is purely registered state.

## Test plan
- Reset, then push PCs 0x80000000, 0x80000004, 0x80000008 with `pop_ready` = 0:
  - `count` = 3 and `full` = 0.
  - `pop_pc` = 0x80000000 from the cycle after the first push.
- Fill 4 entries (DEPTH = 4), then hold `push_valid` = 1 with `pop_ready` = 1 for 1 cycle:
  - In that cycle `push_ready` = 0 and the push is not accepted.
  - The next cycle shows `count` = 3.
- Push 6 entries and pop 6 in interleaved order: output order matches PCs in sequence across the pointer wrap, and `count` returns to 0.
- Push an entry with `iaddr_illegal` = 1, `push_inst` = 0x24020001:
  - The popped entry has inst 0x00000000 and `iaddr_illegal` = 1.
  - `push_ready` stays 0 until `flush`.
  - After `flush`, `push_ready` = 1.
- With 3 entries, assert `flush` together with `push_valid` = 1: next cycle `count` = 0 and `pop_valid` = 0, and the pushed word is never popped.
- With `INST_QUEUE_BYPASS_EN` defined, empty queue, push 0x8C010000 at PC 0xBFC00000 with `pop_ready` = 1: same-cycle `pop_valid` = 1, `pop_inst` = 0x8C010000, and `count` stays 0.

Source files
------------

// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue -- instruction queue between fetch and decode.
//
// Buffers fetched instruction words with their PC and fetch exception flags
// in a DEPTH-entry circular buffer, so fetch can run ahead while decode is
// stalled. A pipeline flush discards everything.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             discard all entries (highest priority after rst)
//   push_valid/ready  fetch-side handshake; push_pc/inst/except are the payload
//   pop_valid/ready   decode-side handshake; pop_pc/inst/except show the head
//                     (all zero while pop_valid is 0)
//   count             number of occupied entries
//   full              count == DEPTH, feeds the fetch stall request
//
// Optional feature macro: INST_QUEUE_BYPASS_EN
//   When defined, a push into an empty queue that decode consumes in the
//   same cycle is forwarded combinationally to the pop outputs and is never
//   written into storage.
// ---------------------------------------------------------------------------

package inst_queue_pkg;
    typedef logic [31:0] word_t;

    typedef struct packed {
        logic iaddr_miss;
        logic iaddr_invalid;
        logic iaddr_illegal;
    } exceptType_t;
endpackage

module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push_valid,
    input  word_t                    push_pc,
    input  word_t                    push_inst,
    input  exceptType_t              push_except,
    output logic                     push_ready,
    output logic                     pop_valid,
    output word_t                    pop_pc,
    output word_t                    pop_inst,
    output exceptType_t              pop_except,
    input  logic                     pop_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          exc_hold_q, exc_hold_d;

    word_t         pc_mem   [DEPTH];
    word_t         inst_mem [DEPTH];
    exceptType_t   exc_mem  [DEPTH];

    logic          empty;
    logic          push_fire;
    logic          pop_fire;
    logic          bypass;
    logic          mem_write;
    logic          push_faulted;
    word_t         push_inst_san;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count = wr_ptr_q - rd_ptr_q;

    // Acceptance depends only on registered state, so a pop in the same cycle
    // cannot free a slot for a push while full.
    assign push_ready = !full && !exc_hold_q && !flush;
    assign push_fire  = push_valid && push_ready;

    // A faulting fetch delivers a NOP so decode never sees a garbage word.
    assign push_faulted  = (push_except != '0);
    assign push_inst_san = push_faulted ? 32'h0 : push_inst;

`ifdef INST_QUEUE_BYPASS_EN
    // push_ready already includes !flush, so flush also blocks the bypass.
    assign bypass = push_fire && empty && pop_ready;
`else
    assign bypass = 1'b0;
`endif

    assign pop_valid = !empty || bypass;
    assign pop_fire  = pop_valid && pop_ready && !flush;
    assign mem_write = push_fire && !bypass;

    always_comb begin
        pop_pc     = '0;
        pop_inst   = '0;
        pop_except = '0;
        if (bypass) begin
            pop_pc     = push_pc;
            pop_inst   = push_inst_san;
            pop_except = push_except;
        end else if (!empty) begin
            pop_pc     = pc_mem[rd_ptr_q[AW-1:0]];
            pop_inst   = inst_mem[rd_ptr_q[AW-1:0]];
            pop_except = exc_mem[rd_ptr_q[AW-1:0]];
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        exc_hold_d = exc_hold_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            exc_hold_d = 1'b0;
        end else begin
            if (mem_write) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            // A bypassed entry never reaches storage, so the head stays put.
            if (pop_fire && !bypass) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            // Anything fetched past a faulting PC is useless; stop accepting.
            if (push_fire && push_faulted) begin
                exc_hold_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            exc_hold_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            exc_hold_q <= exc_hold_d;
        end
    end

    // Storage is not reset; contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (mem_write && !rst) begin
            pc_mem[wr_ptr_q[AW-1:0]]   <= push_pc;
            inst_mem[wr_ptr_q[AW-1:0]] <= push_inst_san;
            exc_mem[wr_ptr_q[AW-1:0]]  <= push_except;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_queue -- self-checking bench for inst_queue (DEPTH = 4).
// Directed sequences followed by randomized traffic; every cycle all outputs
// are compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        exceptType_t exc;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        push_valid;
    word_t       push_pc;
    word_t       push_inst;
    exceptType_t push_except;
    logic        push_ready;
    logic        pop_valid;
    word_t       pop_pc;
    word_t       pop_inst;
    exceptType_t pop_except;
    logic        pop_ready;
    logic [2:0]  count;
    logic        full;

    int vectors    = 0;
    int miscompares = 0;

    ent_t m_q[$];
    logic m_hold;

    logic        last_push_ready;
    logic        last_pop_valid;
    logic [31:0] last_pop_pc;
    logic [31:0] last_pop_inst;
    exceptType_t last_pop_except;
    logic [2:0]  last_count;
    logic        last_full;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_pc    (push_pc),
        .push_inst  (push_inst),
        .push_except(push_except),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_pc     (pop_pc),
        .pop_inst   (pop_inst),
        .pop_except (pop_except),
        .pop_ready  (pop_ready),
        .count      (count),
        .full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check all outputs against the model just
    // before the edge, then advance the model with what the edge commits.
    task automatic cycle(input logic r, input logic f, input logic pv,
                         input logic [31:0] pc, input logic [31:0] inst,
                         input exceptType_t ex, input logic pr);
        int   n;
        logic e_pr;
        logic e_pv;
        logic byp;
        logic acc;
        ent_t san;
        ent_t head;
        rst = r; flush = f; push_valid = pv; push_pc = pc;
        push_inst = inst; push_except = ex; pop_ready = pr;
        #3;
        n        = m_q.size();
        san.pc   = pc;
        san.exc  = ex;
        san.inst = (ex != '0) ? 32'h0 : inst;
        e_pr     = (n < DEPTH) && !m_hold && !f;
        acc      = pv && e_pr;
        byp      = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
        byp      = (n == 0) && acc && pr;
`endif
        e_pv = (n > 0) || byp;
        head.pc = 32'h0; head.inst = 32'h0; head.exc = '0;
        if (byp)        head = san;
        else if (n > 0) head = m_q[0];
        chk("push_ready", 64'(push_ready), 64'(e_pr));
        chk("pop_valid",  64'(pop_valid),  64'(e_pv));
        chk("pop_pc",     64'(pop_pc),     64'(head.pc));
        chk("pop_inst",   64'(pop_inst),   64'(head.inst));
        chk("pop_except", 64'(pop_except), 64'(head.exc));
        chk("count",      64'(count),      64'(n));
        chk("full",       64'(full),       64'(n == DEPTH));
        last_push_ready = push_ready;
        last_pop_valid  = pop_valid;
        last_pop_pc     = pop_pc;
        last_pop_inst   = pop_inst;
        last_pop_except = pop_except;
        last_count      = count;
        last_full       = full;
        @(posedge clk);
        if (r || f) begin
            m_q.delete();
            m_hold = 1'b0;
        end else begin
            if (e_pv && pr && !byp) void'(m_q.pop_front());
            if (acc && !byp) m_q.push_back(san);
            if (acc && ex != '0) m_hold = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input logic pr);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, '0, pr);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst,
                        input exceptType_t ex, input logic pr);
        cycle(1'b0, 1'b0, 1'b1, pc, inst, ex, pr);
    endtask

    exceptType_t no_exc;
    exceptType_t ill_exc;
    exceptType_t rex;

    initial begin
        no_exc  = '0;
        ill_exc = '0;
        ill_exc.iaddr_illegal = 1'b1;
        m_hold  = 1'b0;
        rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_pc = '0;
        push_inst = '0; push_except = '0; pop_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, no_exc, 1'b0);
        chk("rst_push_ready", 64'(last_push_ready), 64'd1);
        chk("rst_pop_valid",  64'(last_pop_valid),  64'd0);
        chk("rst_count",      64'(last_count),      64'd0);

        // Three pushes, decode stalled
        push(32'h8000_0000, 32'h1111_0000, no_exc, 1'b0);
        push(32'h8000_0004, 32'h1111_0004, no_exc, 1'b0);
        chk("tp1_head_pc", 64'(last_pop_pc), 64'h8000_0000);
        push(32'h8000_0008, 32'h1111_0008, no_exc, 1'b0);
        idle(1'b0);
        chk("tp1_count", 64'(last_count), 64'd3);
        chk("tp1_full",  64'(last_full),  64'd0);

        // Fill, then push+pop while full: push rejected
        push(32'h8000_000C, 32'h1111_000C, no_exc, 1'b0);
        push(32'h8000_0010, 32'h1111_0010, no_exc, 1'b1);
        chk("tp2_push_ready_full", 64'(last_push_ready), 64'd0);
        idle(1'b0);
        chk("tp2_count", 64'(last_count), 64'd3);

        // Interleaved push/pop across the pointer wrap
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, no_exc, 1'b0);
        for (int i = 0; i < 6; i++) begin
            push(32'h9000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i), no_exc, 1'b0);
            idle(1'b1);
            chk("tp3_pop_pc", 64'(last_pop_pc), 64'h9000_0000 + 64'(i * 4));
        end
        idle(1'b0);
        chk("tp3_count", 64'(last_count), 64'd0);

        // Faulting fetch: NOP stored, push blocked until flush
        push(32'hBFC0_0100, 32'h2402_0001, ill_exc, 1'b0);
        push(32'hBFC0_0104, 32'h2402_0002, no_exc, 1'b1);
        chk("tp4_pop_inst", 64'(last_pop_inst), 64'h0);
        chk("tp4_pop_illegal", 64'(last_pop_except.iaddr_illegal), 64'd1);
        chk("tp4_held", 64'(last_push_ready), 64'd0);
        push(32'hBFC0_0108, 32'h2402_0003, no_exc, 1'b1);
        chk("tp4_still_held", 64'(last_push_ready), 64'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, no_exc, 1'b0);
        idle(1'b0);
        chk("tp4_released", 64'(last_push_ready), 64'd1);

        // Flush with a concurrent push
        push(32'hC000_0000, 32'h1, no_exc, 1'b0);
        push(32'hC000_0004, 32'h2, no_exc, 1'b0);
        push(32'hC000_0008, 32'h3, no_exc, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, no_exc, 1'b1);
        idle(1'b1);
        chk("tp5_count", 64'(last_count), 64'd0);
        chk("tp5_pop_valid", 64'(last_pop_valid), 64'd0);
        idle(1'b1);

`ifdef INST_QUEUE_BYPASS_EN
        push(32'hBFC0_0000, 32'h8C01_0000, no_exc, 1'b1);
        chk("byp_pop_valid", 64'(last_pop_valid), 64'd1);
        chk("byp_pop_inst",  64'(last_pop_inst),  64'h8C01_0000);
        idle(1'b0);
        chk("byp_count", 64'(last_count), 64'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rex = '0;
            if ($urandom_range(15) == 0) rex = exceptType_t'(3'($urandom_range(1, 7)));
            cycle(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                  ($urandom_range(3) != 0), $urandom, $urandom, rex,
                  ($urandom_range(1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
